// File: rtl/updn_counter_param.sv
// rtl/updn_counter_param.sv - parametrised synchronous up/down counter with load clamp and terminal-count flag
//
// Parameters:
//   WIDTH    counter width in bits (1..32)
//   MAX_VAL  terminal (highest) count (1..2**WIDTH-1)
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bounds
// Ports:
//   CLK    rising-edge clock for all state
//   RST    synchronous active-high reset
//   EN     count enable, gates UP/DOWN only
//   LOAD   parallel load strobe, value clamped to MAX_VAL
//   IN     load value
//   UP     increment request
//   DOWN   decrement request
//   COUNT  registered count
//   HIGH   COUNT == MAX_VAL, decoded from the count register
//   LOW    COUNT == 0, decoded from the count register
//   TC     registered one-cycle flag for a boundary step

module updn_counter_param #(
    parameter int              WIDTH    = 5,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] IN,
    input  logic             UP,
    input  logic             DOWN,
    output logic [WIDTH-1:0] COUNT,
    output logic             HIGH,
    output logic             LOW,
    output logic             TC
);

    // Terminal value in the extended (WIDTH+1 bit) arithmetic domain.
    localparam logic [WIDTH:0] MAX_EXT  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0] ZERO_EXT = '0;
    localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    // The count is kept one bit wider than the port so increments and
    // decrements never silently truncate; the top bit is always zero in
    // any state reachable after reset.
    logic [WIDTH:0] count_q;
    logic           tc_q;

    logic [WIDTH:0] count_d;
    logic           tc_d;

    logic [WIDTH:0] in_ext;
    logic [WIDTH:0] load_val;
    logic [WIDTH:0] inc_val;
    logic [WIDTH:0] dec_val;
    logic           step_up;
    logic           step_down;
    logic           at_top;
    logic           at_bottom;

    assign in_ext    = {1'b0, IN};
    assign load_val  = (in_ext > MAX_EXT) ? MAX_EXT : in_ext;
    assign inc_val   = count_q + ONE_EXT;
    assign dec_val   = count_q - ONE_EXT;

    // Simultaneous UP and DOWN cancel out and leave the count unchanged.
    assign step_up   = EN & UP & ~DOWN;
    assign step_down = EN & DOWN & ~UP;

    // ">=" rather than "==" so a corrupted count above the terminal value
    // is treated as a boundary and steered back into range on the next step.
    assign at_top    = (count_q >= MAX_EXT);
    assign at_bottom = (count_q == ZERO_EXT);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (LOAD) begin
            count_d = load_val;
        end else if (step_up) begin
            if (at_top) begin
                count_d = SATURATE ? MAX_EXT : ZERO_EXT;
                tc_d    = 1'b1;
            end else begin
                count_d = inc_val;
            end
        end else if (step_down) begin
            if (at_bottom) begin
                count_d = SATURATE ? ZERO_EXT : MAX_EXT;
                tc_d    = 1'b1;
            end else begin
                count_d = dec_val;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign COUNT = count_q[WIDTH-1:0];
    assign HIGH  = (count_q == MAX_EXT);
    assign LOW   = (count_q == ZERO_EXT);
    assign TC    = tc_q;

endmodule
